// File: rtl/comp_serial_ctrl.sv
// comp_serial_ctrl: bit-serial magnitude comparator sequencer driving one Comp_1bit cell, MSB first.
module Comp_1bit (
   input  logic a,
   input  logic b,
   input  logic gin,
   input  logic lin,
   input  logic ein,
   output logic gout,
   output logic lout,
   output logic eout
);
   assign gout = gin | (ein & a & ~b);
   assign lout = lin | (ein & ~a & b);
   assign eout = ein & ~(a ^ b);
endmodule

module comp_serial_ctrl #(
   parameter int WIDTH      = 8,
   parameter int EARLY_EXIT = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           a_in,
   input  logic [WIDTH-1:0]           b_in,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       gt,
   output logic                       eq,
   output logic                       lt,
   output logic                       busy,
   output logic [$clog2(WIDTH+1)-1:0] steps
);
   localparam int IW = $clog2(WIDTH);
   localparam int SW = $clog2(WIDTH+1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nxt;
   logic [WIDTH-1:0] a_reg, b_reg;
   logic [IW-1:0] idx;
   logic [SW-1:0] cnt;
   logic g_r, l_r, gout, lout, eout, fin;
   Comp_1bit u_cell (
      .a(a_reg[idx]), .b(b_reg[idx]),
      .gin(g_r), .lin(l_r), .ein(~g_r & ~l_r),
      .gout(gout), .lout(lout), .eout(eout)
   );
   // eout equals ~gout&~lout because the sticky g/l flags are never both set
   assign fin       = ((EARLY_EXIT != 0) && (gout | lout)) || (idx == '0);
   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign out_valid = (state == DONE);
   always_comb begin
      state_nxt = state;
      if (state == IDLE && in_valid) state_nxt = RUN;
      else if (state == RUN && fin) state_nxt = DONE;
      else if (state == DONE && out_ready) state_nxt = IDLE;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         a_reg <= '0;
         b_reg <= '0;
         idx   <= '0;
         cnt   <= '0;
         g_r   <= 1'b0;
         l_r   <= 1'b0;
         gt    <= 1'b0;
         eq    <= 1'b0;
         lt    <= 1'b0;
         steps <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && in_valid) begin
            a_reg <= a_in;
            b_reg <= b_in;
            idx   <= IW'(WIDTH-1);
            cnt   <= '0;
            g_r   <= 1'b0;
            l_r   <= 1'b0;
         end
         if (state == RUN) begin
            g_r <= gout;
            l_r <= lout;
            cnt <= cnt + 1'b1;
            if (fin) begin
               gt    <= gout;
               lt    <= lout;
               eq    <= eout;
               steps <= cnt + 1'b1;
            end else begin
               idx <= idx - 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_comp_serial_ctrl.sv
// tb_comp_serial_ctrl: four comparator configurations run in lockstep against an arithmetic model.
module tb_comp_serial_ctrl;
   logic clk = 1'b0;
   logic rst, in_valid, out_ready;
   logic [12:0] a_in, b_in;
   logic [3:0] in_ready, out_valid, gt, eq, lt, busy;
   logic [3:0] steps [4];
   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   comp_serial_ctrl #(.WIDTH(8), .EARLY_EXIT(1)) u0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
      .a_in(a_in[7:0]), .b_in(b_in[7:0]), .out_valid(out_valid[0]), .out_ready(out_ready),
      .gt(gt[0]), .eq(eq[0]), .lt(lt[0]), .busy(busy[0]), .steps(steps[0]));
   comp_serial_ctrl #(.WIDTH(8), .EARLY_EXIT(0)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
      .a_in(a_in[7:0]), .b_in(b_in[7:0]), .out_valid(out_valid[1]), .out_ready(out_ready),
      .gt(gt[1]), .eq(eq[1]), .lt(lt[1]), .busy(busy[1]), .steps(steps[1]));
   comp_serial_ctrl #(.WIDTH(13), .EARLY_EXIT(1)) u2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]),
      .a_in(a_in), .b_in(b_in), .out_valid(out_valid[2]), .out_ready(out_ready),
      .gt(gt[2]), .eq(eq[2]), .lt(lt[2]), .busy(busy[2]), .steps(steps[2]));
   comp_serial_ctrl #(.WIDTH(13), .EARLY_EXIT(0)) u3 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[3]),
      .a_in(a_in), .b_in(b_in), .out_valid(out_valid[3]), .out_ready(out_ready),
      .gt(gt[3]), .eq(eq[3]), .lt(lt[3]), .busy(busy[3]), .steps(steps[3]));

   function automatic int wid(input int k);
      return (k < 2) ? 8 : 13;
   endfunction

   // Unsigned compare plus step count: first differing bit from the MSB, or full width.
   function automatic void model(input int k, input logic [12:0] a, input logic [12:0] b,
                                 output logic g, output logic e, output logic l, output int s);
      int w, av, bv;
      bit found;
      w  = wid(k);
      av = int'(a) & ((1 << w) - 1);
      bv = int'(b) & ((1 << w) - 1);
      g  = av > bv;
      e  = av == bv;
      l  = av < bv;
      s  = w;
      found = 0;
      if (k % 2 == 0)
         for (int i = w - 1; i >= 0; i--)
            if (!found && (((av >> i) & 1) != ((bv >> i) & 1))) begin
               s = w - i;
               found = 1;
            end
   endfunction

   task automatic do_op(input logic [12:0] a, input logic [12:0] b, input int hold,
                        input bit rnd, input bit junk);
      logic eg [4];
      logic ee [4];
      logic el [4];
      int es [4];
      bit fin [4];
      int cyc;
      bit any_fin, all_fin;
      for (int k = 0; k < 4; k++) begin
         model(k, a, b, eg[k], ee[k], el[k], es[k]);
         fin[k] = 0;
      end
      @(negedge clk);
      a_in = a;
      b_in = b;
      in_valid = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      cyc = 0;
      all_fin = 0;
      while (!all_fin && cyc < 100) begin
         @(negedge clk);
         any_fin = 0;
         for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (fin[k]) begin
               any_fin = 1;
               if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1 || busy[k] !== 1'b0) begin
                  n_fail++;
                  $display("FAIL idle_after_done k=%0d cyc=%0d got ov=%b ir=%b busy=%b exp ov=0 ir=1 busy=0",
                           k, cyc, out_valid[k], in_ready[k], busy[k]);
               end
            end else begin
               if (out_valid[k] !== (cyc >= es[k]) || in_ready[k] !== 1'b0 || busy[k] !== 1'b1) begin
                  n_fail++;
                  $display("FAIL timing k=%0d cyc=%0d a=%h b=%h got ov=%b ir=%b busy=%b exp ov=%b ir=0 busy=1",
                           k, cyc, a, b, out_valid[k], in_ready[k], busy[k], cyc >= es[k]);
               end
            end
            if (fin[k] || cyc >= es[k]) begin
               n_checks++;
               if (gt[k] !== eg[k] || eq[k] !== ee[k] || lt[k] !== el[k] || int'(steps[k]) != es[k]) begin
                  n_fail++;
                  $display("FAIL result k=%0d a=%h b=%h got gt=%b eq=%b lt=%b steps=%0d exp gt=%b eq=%b lt=%b steps=%0d",
                           k, a, b, gt[k], eq[k], lt[k], steps[k], eg[k], ee[k], el[k], es[k]);
               end
               n_checks++;
               if ({1'b0, gt[k]} + {1'b0, eq[k]} + {1'b0, lt[k]} != 2'd1) begin
                  n_fail++;
                  $display("FAIL one_hot k=%0d got gt=%b eq=%b lt=%b exp exactly one", k, gt[k], eq[k], lt[k]);
               end
            end
         end
         out_ready = (cyc < hold) ? 1'b0 : (rnd ? 1'($urandom % 2) : 1'b1);
         in_valid = junk && !any_fin;
         if (junk) begin
            a_in = 13'($urandom);
            b_in = 13'($urandom);
         end
         @(posedge clk);
         all_fin = 1;
         for (int k = 0; k < 4; k++) begin
            if (out_valid[k] && out_ready) fin[k] = 1;
            all_fin = all_fin && fin[k];
         end
         cyc++;
      end
      n_checks++;
      if (!all_fin) begin
         n_fail++;
         $display("FAIL timeout a=%h b=%h got cycles=%0d exp under 100", a, b, cyc);
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b1;
      out_ready = 1'b0;
      a_in = 13'h1234;
      b_in = 13'h0042;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || busy[k] !== 1'b0 ||
             gt[k] !== 1'b0 || eq[k] !== 1'b0 || lt[k] !== 1'b0 || steps[k] !== 4'd0) begin
            n_fail++;
            $display("FAIL reset k=%0d got ir=%b ov=%b busy=%b gt=%b eq=%b lt=%b steps=%0d exp 1,0,0,0,0,0,0",
                     k, in_ready[k], out_valid[k], busy[k], gt[k], eq[k], lt[k], steps[k]);
         end
      end
      in_valid = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_equal();
      do_op(13'h00A5, 13'h00A5, 0, 0, 0);
   endtask

   task automatic test_msb();
      do_op(13'h0080, 13'h007F, 0, 0, 0);
      do_op(13'h1000, 13'h0FFF, 0, 0, 0);
   endtask

   task automatic test_lsb();
      do_op(13'h0012, 13'h0013, 0, 0, 0);
      do_op(13'h0000, 13'h00FF, 0, 0, 0);
   endtask

   task automatic test_backpressure();
      do_op(13'h0040, 13'h003F, 19, 0, 1);
      do_op(13'h0040, 13'h003F, 0, 0, 0);
   endtask

   task automatic test_reset_mid_run();
      @(negedge clk);
      a_in = 13'h0001;
      b_in = 13'h0001;
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || busy[k] !== 1'b0 ||
             gt[k] !== 1'b0 || eq[k] !== 1'b0 || lt[k] !== 1'b0 || steps[k] !== 4'd0) begin
            n_fail++;
            $display("FAIL async_reset k=%0d got ir=%b ov=%b busy=%b gt=%b eq=%b lt=%b steps=%0d exp 1,0,0,0,0,0,0",
                     k, in_ready[k], out_valid[k], busy[k], gt[k], eq[k], lt[k], steps[k]);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (20) begin
         @(negedge clk);
         for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1) begin
               n_fail++;
               $display("FAIL aborted_result k=%0d got ov=%b ir=%b exp ov=0 ir=1", k, out_valid[k], in_ready[k]);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [12:0] a, b;
      int r;
      for (int n = 0; n < 2000; n++) begin
         a = 13'($urandom);
         r = $urandom_range(0, 7);
         b = (r == 0) ? a : (r < 3) ? a ^ 13'(1 << $urandom_range(0, 12)) : 13'($urandom);
         do_op(a, b, $urandom_range(0, 3) == 0 ? $urandom_range(0, 16) : 0, 1, $urandom_range(0, 1) == 1);
      end
   endtask

   initial begin
      test_reset();
      test_equal();
      test_msb();
      test_lsb();
      test_backpressure();
      test_reset_mid_run();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
